// File: rtl/multicycle_adder.sv
// Sequential adder/subtractor: processes CHUNK bits per clock, carrying
// between slices, with a start/busy/done handshake.
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] partial_next;
    logic             carry;
    logic [CHUNK:0]   slice;
    logic             last;
    logic             msb_cin;

    // Operands shift down so the active slice always sits in the low bits;
    // results enter at the top of partial and shift down into place.
    assign slice = {1'b0, a_q[CHUNK-1:0]}
                 + {1'b0, b_q[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry};

    assign partial_next = (partial >> CHUNK)
                        | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));

    assign last    = (idx == IW'(NCHUNK - 1));
    assign msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice[CHUNK-1];
    assign busy    = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry   <= 1'b0;
            partial <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    partial <= partial_next;
                    carry   <= slice[CHUNK];
                    idx     <= idx + IW'(1);
                    if (last) begin
                        sum   <= partial_next;
                        cout  <= slice[CHUNK];
                        ovf   <= msb_cin ^ slice[CHUNK];
                        done  <= 1'b1;
                        idx   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder: default instance with directed
// and random operations, plus a parameter sweep of further instances.
module tb_multicycle_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_issued = 0;
    int done_cnt = 0;
    logic [3:0] sw_fin = '0;

    logic [33:0] exp_q[$];
    int          acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub),
        .a(a), .b(b), .cin(cin), .busy(busy), .done(done),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/cout,
    // signed range test for overflow.
    function automatic logic [33:0] ref_model(input int w, input logic s,
                                              input logic [31:0] x,
                                              input logic [31:0] y,
                                              input logic c);
        longint m, ux, uy, sx, sy, cc, r, sr;
        logic co, ov;
        logic [63:0] rv;
        m  = longint'(1) << w;
        ux = longint'(x) & (m - 1);
        uy = longint'(y) & (m - 1);
        cc = c ? 1 : 0;
        sx = (ux >= m / 2) ? ux - m : ux;
        sy = (uy >= m / 2) ? uy - m : uy;
        if (s) begin
            r  = ux - uy - cc;
            co = (ux >= uy + cc);
            sr = sx - sy - cc;
        end else begin
            r  = ux + uy + cc;
            co = (r >= m);
            sr = sx + sy + cc;
        end
        ov = (sr >= m / 2) || (sr < -(m / 2));
        rv = 64'(r & (m - 1));
        return {ov, co, rv[31:0]};
    endfunction

    always @(negedge clk) begin
        logic [33:0] e;
        int ac;
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(1), 64'(0));
            end else begin
                e  = exp_q.pop_front();
                ac = acc_q.pop_front();
                chk("sum", 64'(sum), 64'(e[31:0]));
                chk("cout", 64'(cout), 64'(e[32]));
                chk("ovf", 64'(ovf), 64'(e[33]));
                chk("latency", 64'(cyc - ac), 64'(4));
            end
        end
    end

    task automatic issue(input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic c);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 64'(busy), 64'(0));
        sub = s; a = x; b = y; cin = c; start = 1'b1;
        exp_q.push_back(ref_model(32, s, x, y, c));
        acc_q.push_back(cyc + 1);
        n_issued++;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
    endtask

    logic [32:0] dir_ab[7][2];
    logic [1:0]  dir_sc[7];
    initial begin
        dir_sc[0] = 2'b01; dir_ab[0][0] = 33'h0000000F; dir_ab[0][1] = 33'h00000010;
        dir_sc[1] = 2'b00; dir_ab[1][0] = 33'h000000FF; dir_ab[1][1] = 33'h00000001;
        dir_sc[2] = 2'b00; dir_ab[2][0] = 33'hFFFFFFFF; dir_ab[2][1] = 33'h00000001;
        dir_sc[3] = 2'b00; dir_ab[3][0] = 33'h7FFFFFFF; dir_ab[3][1] = 33'h00000001;
        dir_sc[4] = 2'b10; dir_ab[4][0] = 33'h00000005; dir_ab[4][1] = 33'h00000007;
        dir_sc[5] = 2'b11; dir_ab[5][0] = 33'h00000007; dir_ab[5][1] = 33'h00000005;
        dir_sc[6] = 2'b10; dir_ab[6][0] = 33'h80000000; dir_ab[6][1] = 33'h00000001;
    end

    initial begin
        int cnt;
        int acc[3];
        int n;
        reset = 1'b1; start = 1'b0; sub = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        reset = 1'b0;

        issue(dir_sc[0][1], dir_ab[0][0][31:0], dir_ab[0][1][31:0], dir_sc[0][0]);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(cnt), 64'(4));
        drain();

        for (int i = 1; i < 7; i++) begin
            issue(dir_sc[i][1], dir_ab[i][0][31:0], dir_ab[i][1][31:0], dir_sc[i][0]);
            drain();
        end

        // start pulsed mid-run must be ignored
        issue(1'b0, 32'h11111111, 32'h22222222, 1'b0);
        sub = 1'b1; a = 32'hFFFFFFFF; b = 32'h12345678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (6) @(negedge clk);
        chk("ignored_start", 64'(done_cnt), 64'(n_issued));

        // start held high: back-to-back acceptance on the done cycle
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (busy && n < 100) begin
                @(negedge clk);
                n++;
            end
            sub = 1'($urandom); a = $urandom; b = $urandom; cin = 1'($urandom);
            exp_q.push_back(ref_model(32, sub, a, b, cin));
            acc_q.push_back(cyc + 1);
            acc[k] = cyc + 1;
            n_issued++;
            @(negedge clk);
        end
        start = 1'b0;
        drain();
        chk("b2b_gap0", 64'(acc[1] - acc[0]), 64'(5));
        chk("b2b_gap1", 64'(acc[2] - acc[1]), 64'(5));

        // reset two edges into a run, with start also asserted
        @(negedge clk);
        sub = 1'b0; a = 32'h0F0F0F0F; b = 32'h01010101; cin = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_sum", 64'(sum), 64'(0));
        chk("mid_rst_cout", 64'(cout), 64'(0));
        chk("mid_rst_ovf", 64'(ovf), 64'(0));
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_priority", 64'(busy), 64'(0));
        repeat (8) @(negedge clk);
        chk("no_done_after_rst", 64'(done_cnt), 64'(n_issued));
        issue(1'b0, 32'h0F0F0F0F, 32'h01010101, 1'b1);
        drain();

        for (int k = 0; k < 30; k++) begin
            issue(1'($urandom), $urandom, $urandom, 1'($urandom));
        end
        drain();

        n = 0;
        while (sw_fin != 4'hF && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("sweep_finish", 64'(sw_fin), 64'hF);
        chk("done_count", 64'(done_cnt), 64'(n_issued));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    for (genvar g = 0; g < 4; g++) begin : sw
        localparam int W = (g == 3) ? 16 : 32;
        localparam int C = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 32 : 16;
        localparam int N = W / C;

        logic         rst, st, sb, ci, bz, dn, co, ov;
        logic [W-1:0] xa, xb, sm;
        logic [33:0]  q[$];
        int           aq[$];
        logic [33:0]  e;
        int           ac;

        multicycle_adder #(.WIDTH(W), .CHUNK(C)) u (
            .clk(clk), .reset(rst), .start(st), .sub(sb),
            .a(xa), .b(xb), .cin(ci), .busy(bz), .done(dn),
            .sum(sm), .cout(co), .ovf(ov)
        );

        initial begin
            int n;
            rst = 1'b1; st = 1'b0; sb = 1'b0; ci = 1'b0;
            xa = '0; xb = '0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 20; k++) begin
                n = 0;
                while (bz && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk($sformatf("sw%0d_idle", g), 64'(bz), 64'(0));
                sb = 1'($urandom); ci = 1'($urandom);
                xa = W'($urandom); xb = W'($urandom);
                if (k == 0) begin
                    sb = 1'b0; ci = 1'b1; xa = '1; xb = '0;
                end
                st = 1'b1;
                q.push_back(ref_model(W, sb, 32'(xa), 32'(xb), ci));
                aq.push_back(cyc + 1);
                @(negedge clk);
                st = 1'b0;
                xa = W'($urandom); xb = W'($urandom);
            end
            n = 0;
            while (q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("sw%0d_drain", g), 64'(q.size()), 64'(0));
            sw_fin[g] = 1'b1;
        end

        always @(negedge clk) begin
            if (dn) begin
                if (q.size() == 0) begin
                    chk($sformatf("sw%0d_unexpected", g), 64'(1), 64'(0));
                end else begin
                    e  = q.pop_front();
                    ac = aq.pop_front();
                    chk($sformatf("sw%0d_sum", g), 64'(sm), 64'(e[31:0]));
                    chk($sformatf("sw%0d_cout", g), 64'(co), 64'(e[32]));
                    chk($sformatf("sw%0d_ovf", g), 64'(ov), 64'(e[33]));
                    chk($sformatf("sw%0d_lat", g), 64'(cyc - ac), 64'(N));
                end
            end
        end
    end

endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised, sequential successor to the team's 32-bit ripple adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between slices internally, and reports sum, carry-out and signed overflow through a start/busy/done handshake. It sits in the datapath where a full-width combinational carry chain would limit clock frequency, trading latency for a short critical path.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per clock. Must divide WIDTH exactly; 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle (busy=0).
- sub  input  1  0: a + b + cin; 1: a − b − cin (cin acts as borrow-in).
- a  input  WIDTH  operand A, sampled on the accepting edge only.
- b  input  WIDTH  operand B, sampled on the accepting edge only.
- cin  input  1  carry-in (sub=0) or borrow-in (sub=1), sampled on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- sum  output  WIDTH  result, held until the next completion.
- cout  output  1  raw carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN. Chunk index counter idx ranges 0..NCHUNK−1.
- IDLE, start=1: accept. Latch a, b_eff = sub ? ~b : b, carry = sub ? ~cin : cin. Go to RUN with idx=0 and busy=1.
- RUN, each edge: compute slice idx as a[idx] + b_eff[idx] + carry, with CHUNK+1-bit internal width. Write the slice to the internal partial register, update carry, increment idx.
- RUN, edge processing idx=NCHUNK−1:
  - Copy partial to sum, final carry to cout, and compute ovf.
  - Set done=1 and busy=0, and return to IDLE.
  - Capture the carry into the MSB during this slice.
- sum, cout and ovf change only on completion edges. Intermediate slices are never visible.
- start while busy=1 is ignored. It is neither queued nor latched.
- start=1 in the cycle done=1 is high (state IDLE) is accepted. This gives back-to-back operation.
- Arithmetic is modulo 2^WIDTH. With sub=1, a − b − cin equals a + ~b + ~cin.
- Reset (any state, including mid-RUN):
  - Next edge forces IDLE and idx=0.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - An in-flight operation is discarded, and no done is produced for it.
  - reset has priority over start in the same cycle.

## Timing
- Accept edge E0. Slices are processed on edges E1..E_NCHUNK. done=1 is registered at E_NCHUNK and high for exactly one cycle.
- Latency from the accepting edge to done: NCHUNK edges. For defaults (NCHUNK=4), done is high after the 4th edge following acceptance.
- busy is high from E0 up to E_NCHUNK, where it drops in the same edge done rises.
- Minimum issue interval: NCHUNK+1 cycles (start held high continuously).
- CHUNK=WIDTH: NCHUNK=1, and done follows the accepting edge by one edge.
- Operands may change freely after the accepting edge.

## Test plan
- Defaults, sub=0, a=0x0000000F, b=0x00000010, cin=1 -> sum=0x00000020, cout=0, ovf=0. done pulses once, 4 edges after acceptance; busy is high for exactly 4 cycles.
- Cross-chunk carry:
  - 0x000000FF + 0x00000001, cin=0 -> 0x00000100.
  - 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, cout=1, ovf=0.
  - 0x7FFFFFFF + 0x00000001 -> 0x80000000, cout=0, ovf=1.
- Subtract:
  - 5 − 7, cin=0 -> sum=0xFFFFFFFE, cout=0.
  - 7 − 5, cin=1 -> sum=0x00000001, cout=1.
  - 0x80000000 − 1 -> 0x7FFFFFFF, ovf=1.
- Handshake:
  - start pulsed mid-RUN with different operands -> ignored; the first result is unchanged.
  - start held high -> a new operation is accepted on the done cycle; results arrive every 5 cycles.
- Reset asserted 2 edges into RUN -> next edge busy=0, done=0, sum=0, cout=0, ovf=0. No done appears afterwards, and a fresh start then completes normally.
- Parameter sweep: CHUNK=1, 4, 32 with WIDTH=32, and WIDTH=16/CHUNK=16. Random operands must match a + b + cin (or a − b − cin) mod 2^WIDTH with reference cout/ovf. Latency must equal NCHUNK.
